// File: rtl/rns_pkg.sv
// Shared constants and FSM state type for the RNS residue channels.
// Holds the residue width, the channel moduli and the 2-bit state enum.
package rns_pkg;

  localparam int RNS_WIDTH = 6;
  localparam int RNS_MOD0  = 61;
  localparam int RNS_MOD1  = 63;
  localparam int RNS_MOD2  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rns_mod_step.sv
// One interleaved shift-add step: acc_o = (2*acc_i + bit_i*a_i) mod MOD.
// Ports: acc_i, a_i (WIDTH), bit_i (1) -> acc_o (WIDTH). Combinational.
module rns_mod_step
  import rns_pkg::*;
#(
  parameter int WIDTH = RNS_WIDTH,
  parameter int MOD   = RNS_MOD0
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] acc_o
);

  // One extra bit so MOD == 2**WIDTH is representable.
  localparam logic [WIDTH:0] MODC = (WIDTH+1)'(MOD);

  logic [WIDTH:0] dbl;
  logic [WIDTH:0] red1;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] red2;

  // Each single subtract suffices since both addends are < MOD.
  always_comb begin
    dbl   = {acc_i, 1'b0};
    red1  = (dbl >= MODC) ? dbl - MODC : dbl;
    sum   = bit_i ? red1 + {1'b0, a_i} : red1;
    red2  = (sum >= MODC) ? sum - MODC : sum;
    acc_o = WIDTH'(red2);
  end

endmodule

// File: rtl/rns_modmul_seq.sv
// Sequential (a*b) mod MOD, MSB-first, one multiplier bit per cycle.
// Ports: clk, rst_n, in_valid/in_ready/in_a/in_b, out_valid/out_ready/
// out_result; out_err only with RNS_MODMUL_RANGE_CHECK_EN defined.
module rns_modmul_seq
  import rns_pkg::*;
#(
  parameter int WIDTH = RNS_WIDTH,
  parameter int MOD   = RNS_MOD0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
`ifdef RNS_MODMUL_RANGE_CHECK_EN
  ,
  output logic             out_err
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] step;

`ifdef RNS_MODMUL_RANGE_CHECK_EN
  localparam logic [WIDTH:0] MODC = (WIDTH+1)'(MOD);
  logic err_q, err_d;
  logic bad;
  assign bad = ({1'b0, in_a} >= MODC) |
               ({1'b0, in_b} >= MODC);
  assign out_err = err_q;
`endif

  rns_mod_step #(
    .WIDTH(WIDTH),
    .MOD  (MOD)
  ) u_step (
    .acc_i(acc_q),
    .a_i  (a_q),
    .bit_i(b_q[cnt_q]),
    .acc_o(step)
  );

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = acc_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef RNS_MODMUL_RANGE_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          acc_d = '0;
          cnt_d = CW'(WIDTH-1);
`ifdef RNS_MODMUL_RANGE_CHECK_EN
          // Bad operands skip RUN; acc stays 0.
          err_d   = bad;
          state_d = bad ? DONE : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        acc_d = step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef RNS_MODMUL_RANGE_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef RNS_MODMUL_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef RNS_MODMUL_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule
